wb_write_arbiter: RTL and testbench

Write-back stage arbiter producing the single register-file write port (RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb). The same signals feed the WB-to-ID forwarding logic. The block merges two write sources: the in-order pipeline result from the MEM/WB path, and results from a long-latency unit (multiplier/divider) through a small FIFO. It also keeps a busy scoreboard of registers awaiting long-latency results, so ID can stall on RAW/WAW hazards.

---
 rtl/wb_write_arbiter_if.sv | 32 +++
 rtl/wb_write_arbiter.sv | 110 +++++++++++
 tb/tb_wb_write_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// Write-back arbiter bus: pipeline write request, long-latency result handshake,
// issue tracking, and the registered register-file write port.
interface wb_write_arbiter_if;
    logic        RegWrite_mem;
    logic [4:0]  RegWriteAddr_mem;
    logic [31:0] RegWriteData_mem;
    logic        Lu_valid;
    logic        Lu_ready;
    logic [4:0]  Lu_addr;
    logic [31:0] Lu_data;
    logic        Issue_valid;
    logic [4:0]  Issue_addr;
    logic        RegWrite_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic [31:0] RegWriteData_wb;
    logic [31:0] Busy_mask;
    logic        Stall_req;

    modport master (
        output RegWrite_mem, RegWriteAddr_mem, RegWriteData_mem,
        output Lu_valid, Lu_addr, Lu_data, Issue_valid, Issue_addr,
        input  Lu_ready, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
        input  Busy_mask, Stall_req
    );

    modport slave (
        input  RegWrite_mem, RegWriteAddr_mem, RegWriteData_mem,
        input  Lu_valid, Lu_addr, Lu_data, Issue_valid, Issue_addr,
        output Lu_ready, RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb,
        output Busy_mask, Stall_req
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges the in-order pipeline write and queued long-latency results onto the
// single register-file write port, and tracks registers awaiting long-latency writes.
module wb_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    wb_write_arbiter_if.slave   bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    logic [4:0]    fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   busy_q, busy_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [31:0]   wb_data_q, wb_data_d;

    logic          nonempty, stall, ready, pv, push, pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    always_comb begin
        nonempty  = (count_q != '0);
        stall     = nonempty && (wait_q == WAIT_MAX);
        ready     = (count_q < DEPTH_C);
        head_addr = fifo_addr_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
        pv        = bus.RegWrite_mem && (bus.RegWriteAddr_mem != 5'd0);
        push      = bus.Lu_valid && ready;
        // A starved head preempts the pipe; otherwise the FIFO only fills idle slots.
        pop       = nonempty && (stall || !pv);

        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            if (head_addr != 5'd0) begin
                wb_we_d   = 1'b1;
                wb_addr_d = head_addr;
                wb_data_d = head_data;
            end
        end else if (pv) begin
            wb_we_d   = 1'b1;
            wb_addr_d = bus.RegWriteAddr_mem;
            wb_data_d = bus.RegWriteData_mem;
        end

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        wait_d = wait_q;
        if (!nonempty || pop)       wait_d = '0;
        else if (wait_q != WAIT_MAX) wait_d = wait_q + WW'(1);

        // Clear before set so a same-cycle reissue keeps the register busy.
        busy_d = busy_q;
        if (pop) busy_d[head_addr] = 1'b0;
        if (bus.Issue_valid && (bus.Issue_addr != 5'd0)) busy_d[bus.Issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            busy_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Storage needs no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.Lu_addr;
            fifo_data_q[wr_ptr_q] <= bus.Lu_data;
        end
    end

    assign bus.Lu_ready        = ready;
    assign bus.Stall_req       = stall;
    assign bus.Busy_mask       = busy_q;
    assign bus.RegWrite_wb     = wb_we_q;
    assign bus.RegWriteAddr_wb = wb_addr_q;
    assign bus.RegWriteData_wb = wb_data_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench: a queue-based reference model predicts every
// register-file write; a monitor pops and compares them as the DUT emits them.
module tb_wb_write_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_write_arbiter_if bus();
    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         m_fifo[$];
    wr_t         exp_q[$];
    int          m_wait = 0;
    logic [31:0] m_busy = '0;
    int          vectors = 0;
    int          miscompares = 0;

    initial begin
        bus.RegWrite_mem = 0; bus.RegWriteAddr_mem = 0; bus.RegWriteData_mem = 0;
        bus.Lu_valid = 0; bus.Lu_addr = 0; bus.Lu_data = 0;
        bus.Issue_valid = 0; bus.Issue_addr = 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: check state-derived outputs against the model, drive inputs,
    // then advance the model by what the spec says this cycle does.
    task automatic cyc(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ia, input bit do_chk = 1'b1);
        bit  ready, stall, pv, was_empty, popped;
        wr_t e;
        @(negedge clk);
        ready = (m_fifo.size() < DEPTH);
        stall = (m_fifo.size() != 0) && (m_wait == LIMIT);
        if (do_chk) begin
            chk("Lu_ready", {31'd0, bus.Lu_ready}, {31'd0, ready});
            chk("Stall_req", {31'd0, bus.Stall_req}, {31'd0, stall});
            chk("Busy_mask", bus.Busy_mask, m_busy);
        end
        rst = r;
        bus.RegWrite_mem = we; bus.RegWriteAddr_mem = wa; bus.RegWriteData_mem = wd;
        bus.Lu_valid = lv; bus.Lu_addr = la; bus.Lu_data = ld;
        bus.Issue_valid = iv; bus.Issue_addr = ia;
        if (r) begin
            m_fifo.delete();
            exp_q.delete();
            m_wait = 0;
            m_busy = '0;
        end else begin
            pv        = we && (wa != 0);
            was_empty = (m_fifo.size() == 0);
            popped    = 1'b0;
            if (stall || (!pv && !was_empty)) begin
                e = m_fifo.pop_front();
                popped = 1'b1;
                if (e.a != 0) exp_q.push_back(e);
                m_busy[e.a] = 1'b0;
            end else if (pv) begin
                exp_q.push_back(wr_t'{a: wa, d: wd});
            end
            if (popped || was_empty) m_wait = 0;
            else if (m_wait < LIMIT) m_wait++;
            if (lv && ready) m_fifo.push_back(wr_t'{a: la, d: ld});
            if (iv && ia != 0) m_busy[ia] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Every expected write is due at the edge right after it was predicted.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.RegWrite_wb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wb_unexpected: got write addr %0d data %0h, expected none at %0t",
                             bus.RegWriteAddr_wb, bus.RegWriteData_wb, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", {27'd0, bus.RegWriteAddr_wb}, {27'd0, e.a});
                    chk("wb_data", bus.RegWriteData_wb, e.d);
                end
            end else begin
                chk("wb_missed", exp_q.size(), 0);
                exp_q.delete();
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        idle();
        chk("rst_we", {31'd0, bus.RegWrite_wb}, 0);
        chk("rst_addr", {27'd0, bus.RegWriteAddr_wb}, 0);
        chk("rst_data", bus.RegWriteData_wb, 0);
        idle();

        // Reset mid-stream discards two queued entries.
        cyc(0, 1, 5'd5, 32'h1, 1, 5'd10, 32'hA0, 1, 5'd10);
        cyc(0, 1, 5'd5, 32'h2, 1, 5'd11, 32'hB0, 1, 5'd11);
        cyc(1, 1, 5'd5, 32'h3, 1, 5'd12, 32'hC0, 1, 5'd12);
        idle();
        chk("midrst_we", {31'd0, bus.RegWrite_wb}, 0);
        chk("midrst_addr", {27'd0, bus.RegWriteAddr_wb}, 0);
        chk("midrst_data", bus.RegWriteData_wb, 0);
        chk("midrst_ready", {31'd0, bus.Lu_ready}, 1);
        chk("midrst_busy", bus.Busy_mask, 0);
        repeat (4) idle();

        // Pipe wins the slot; the FIFO entry follows.
        cyc(0, 1, 5'd5, 32'hAAAA0001, 1, 5'd7, 32'h1234, 0, 0);
        idle();
        chk("prio_pipe", {bus.RegWrite_wb, bus.RegWriteAddr_wb, 26'd0}, {1'b1, 5'd5, 26'd0});
        chk("prio_pipe_d", bus.RegWriteData_wb, 32'hAAAA0001);
        idle();
        chk("prio_lu", {bus.RegWrite_wb, bus.RegWriteAddr_wb, 26'd0}, {1'b1, 5'd7, 26'd0});
        chk("prio_lu_d", bus.RegWriteData_wb, 32'h1234);
        repeat (2) idle();

        // Starvation under continuous pipe writes.
        cyc(0, 1, 5'd5, 32'h50, 1, 5'd9, 32'h99, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 1, 5'd5, 32'h50 + k, 0, 0, 0, 0, 0);
            chk("starve_stall", {31'd0, bus.Stall_req}, (k == 5) ? 32'd1 : 32'd0);
        end
        cyc(0, 1, 5'd5, 32'h60, 0, 0, 0, 0, 0);
        chk("starve_wb9", {bus.RegWrite_wb, bus.RegWriteAddr_wb, 26'd0}, {1'b1, 5'd9, 26'd0});
        idle();
        chk("starve_pipe", {bus.RegWrite_wb, bus.RegWriteAddr_wb, 26'd0}, {1'b1, 5'd5, 26'd0});
        repeat (3) idle();

        // Full FIFO with Lu_valid held under continuous pipe writes.
        for (int k = 0; k < 9; k++) begin
            cyc(0, 1, 5'd6, 32'h700 + k, 1, 5'(20 + k), 32'h800 + k, 0, 0);
            if (k == 2) chk("full_ready_c2", {31'd0, bus.Lu_ready}, 0);
            if (k == 5) chk("full_ready_pop", {30'd0, bus.Lu_ready, bus.Stall_req}, 32'd1);
            if (k == 6) chk("full_ready_drop", {31'd0, bus.Lu_ready}, 1);
        end
        repeat (8) idle();

        // Scoreboard: reissue in the retire cycle keeps the bit set.
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd3);
        cyc(0, 0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 5'd3);
        idle();
        chk("sb_keep", {31'd0, bus.Busy_mask[3]}, 1);
        chk("sb_keep_wb", {bus.RegWrite_wb, bus.RegWriteAddr_wb, 26'd0}, {1'b1, 5'd3, 26'd0});
        cyc(0, 0, 0, 0, 1, 5'd3, 32'h34, 0, 0);
        idle();
        idle();
        chk("sb_clear", {31'd0, bus.Busy_mask[3]}, 0);
        chk("sb_clear_wb", {bus.RegWrite_wb, bus.RegWriteAddr_wb, 26'd0}, {1'b1, 5'd3, 26'd0});
        idle();

        // Register 0 is never written or marked busy.
        cyc(0, 1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF, 1, 5'd0);
        idle();
        chk("zero_pipe_we", {31'd0, bus.RegWrite_wb}, 0);
        idle();
        chk("zero_lu_we", {31'd0, bus.RegWrite_wb}, 0);
        chk("zero_busy0", {31'd0, bus.Busy_mask[0]}, 0);
        idle();

        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 4) == 0), 5'($urandom_range(0, 31)));
        end
        repeat (12) idle();
        @(posedge clk);
        #2;
        chk("exp_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
